perf_monitor: RTL and testbench
===============================

PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter: CNT_W, 16, width of every event counter and of rdata.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  level; starts a measurement run from IDLE.
REQ-005 clr  input  1  level; synchronous clear of all counters and FSM, any state.
REQ-006 finish  input  1  level; ends the run (driven by bench completion flag).
REQ-007 stall  input  1  pipeline memory-stall indication from CHIP.
REQ-008 flush  input  1  instruction-flush (misprediction) indication from CHIP.
REQ-009 br_type  input  1  resolving instruction is a conditional branch.
REQ-010 i_addr  input  30  word fetch address from CHIP (ICACHE_addr).
REQ-011 rsel  input  3  readout select.
REQ-012 rdata  output  CNT_W  registered readout of selected counter.
REQ-013 running  output  1  high while FSM in RUN.
REQ-014 done  output  1  high while FSM in DONE.
REQ-015 ovf  output  1  sticky: some counter saturated during current run.

Function
REQ-016 FSM states IDLE, RUN, DONE; priority per cycle: clr > finish > en.
REQ-017 IDLE -> RUN when en=1 and clr=0; counting begins the cycle after the transition.
REQ-018 RUN -> DONE when finish=1 and clr=0; the finish cycle is itself counted, counters frozen afterwards.
REQ-019 DONE holds until clr=1; en and finish are ignored in DONE.
REQ-020 clr=1 in any state: next cycle state IDLE, all five counters 0, ovf 0, last-address register 0.
REQ-021 In RUN, each cycle: cyc_cnt +1 unconditionally.
REQ-022 In RUN: stall_cnt +1 when stall=1.
REQ-023 In RUN: br_cnt +1 when br_type=1 and stall=0.
REQ-024 In RUN: mis_cnt +1 when flush=1 and stall=0.
REQ-025 In RUN: fetch_cnt +1 when stall=0 and i_addr differs from last-address register; register loads i_addr whenever stall=0 (in RUN only).
REQ-026 First unstalled cycle of a run compares against 0 (value after reset/clr or the last value from a prior run).
REQ-027 Every counter saturates at 2^CNT_W-1; an increment attempt at saturation holds value and sets ovf.
REQ-028 Multiple events in one cycle all counted independently; stall=1 with flush=1 counts stall only.
REQ-029 rsel map: 0 cyc_cnt, 1 stall_cnt, 2 br_cnt, 3 mis_cnt, 4 fetch_cnt, 5-7 zero.
REQ-030 rdata is registered: value reflects rsel and counters as of the previous rising edge (1-cycle latency), readable in any state.
REQ-031 running and done are decoded directly from the state register (no extra latency).
REQ-032 Inputs other than clr, en, finish, rsel are ignored outside RUN.

Reset
REQ-033 rst_n=0 asynchronously forces IDLE, all counters 0, last-address 0, rdata 0, ovf 0, running 0, done 0.
REQ-034 Reset asserted mid-run discards the run; after release FSM waits in IDLE for en.
REQ-035 No output toggles while rst_n=0 regardless of inputs.

Verification
REQ-036 Reset release, en=1 for 1 cycle, 10 RUN cycles with stall=0, i_addr incrementing each cycle, finish on 10th -> done=1, cyc=10, fetch=10, stall=0.
REQ-037 In RUN: stall=1 for 4 cycles with flush=1 and br_type=1 throughout, then 2 unstalled cycles flush=1 br_type=1 -> stall=4, mis=2, br=2.
REQ-038 CNT_W=4, run 20 cycles -> cyc=15, ovf=1; clr -> cyc=0, ovf=0, state IDLE.
REQ-039 clr and finish asserted together in RUN -> IDLE next cycle, all counters 0, done=0.
REQ-040 rst_n pulsed low mid-run with cyc=7 -> counters 0 immediately, running=0; en after release restarts from 0.
REQ-041 In DONE, rsel stepped 0..7 -> rdata follows map one cycle later, 5-7 read 0; en/finish toggling changes nothing.

Source files
------------

// File: rtl/perf_monitor.sv
// Run-based performance monitor: counts cycles, stalls, branches, mispredicts and
// distinct fetch addresses between en and finish, with saturating counters and a registered readout.
module perf_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             finish,
  input  logic             stall,
  input  logic             flush,
  input  logic             br_type,
  input  logic [29:0]      i_addr,
  input  logic [2:0]       rsel,
  output logic [CNT_W-1:0] rdata,
  output logic             running,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_CNT = 5;
  localparam int CYC     = 0;
  localparam int STL     = 1;
  localparam int BR      = 2;
  localparam int MIS     = 3;
  localparam int FETCH   = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic [CNT_W-1:0] cnt_d [NUM_CNT];
  logic [29:0]      last_addr_q, last_addr_d;
  logic [CNT_W-1:0] rdata_q, rdata_d;
  logic             ovf_q, ovf_d;
  logic [NUM_CNT-1:0] inc;

  // Event qualification: a stalled cycle counts only as a stall, whatever else is asserted.
  always_comb begin
    inc        = '0;
    inc[CYC]   = 1'b1;
    inc[STL]   = stall;
    inc[BR]    = br_type & ~stall;
    inc[MIS]   = flush & ~stall;
    inc[FETCH] = ~stall & (i_addr != last_addr_q);
  end

  always_comb begin
    state_d     = state_q;
    last_addr_d = last_addr_q;
    ovf_d       = ovf_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    if (clr) begin
      state_d     = IDLE;
      last_addr_d = '0;
      ovf_d       = 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en) state_d = RUN;
        end
        RUN: begin
          for (int i = 0; i < NUM_CNT; i++) begin
            if (inc[i]) begin
              if (cnt_q[i] == CNT_MAX) ovf_d = 1'b1;
              else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
          if (!stall) last_addr_d = i_addr;
          if (finish) state_d = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Readout samples the counters as they stand before this edge's update.
  always_comb begin
    rdata_d = '0;
    case (rsel)
      3'd0:    rdata_d = cnt_q[CYC];
      3'd1:    rdata_d = cnt_q[STL];
      3'd2:    rdata_d = cnt_q[BR];
      3'd3:    rdata_d = cnt_q[MIS];
      3'd4:    rdata_d = cnt_q[FETCH];
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_addr_q <= '0;
      rdata_q     <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      last_addr_q <= last_addr_d;
      rdata_q     <= rdata_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rdata   = rdata_q;
  assign ovf     = ovf_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// Testbench for perf_monitor: a 16-bit and a 4-bit instance share stimulus and are
// compared each cycle against an unbounded-count reference model with saturation applied on readout.
module tb_perf_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0, clr = 1'b0, finish = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, br_type = 1'b0;
  logic [29:0] i_addr = '0;
  logic [2:0]  rsel = '0;

  logic [15:0] rdata16;
  logic        running16, done16, ovf16;
  logic [3:0]  rdata4;
  logic        running4, done4, ovf4;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 run, 2 done; raw event counts never wrap.
  int          mstate;
  longint      mcnt [5];
  logic [29:0] mlast;
  longint      exp_raw;

  always #5 clk = ~clk;

  perf_monitor #(.CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .finish(finish),
    .stall(stall), .flush(flush), .br_type(br_type), .i_addr(i_addr),
    .rsel(rsel), .rdata(rdata16), .running(running16), .done(done16), .ovf(ovf16)
  );

  perf_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .finish(finish),
    .stall(stall), .flush(flush), .br_type(br_type), .i_addr(i_addr),
    .rsel(rsel), .rdata(rdata4), .running(running4), .done(done4), .ovf(ovf4)
  );

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic logic anySat(input int w);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 5; i++) if (mcnt[i] > (longint'(1) << w) - 1) r = 1'b1;
    return r;
  endfunction

  task automatic modelClear();
    mstate = 0;
    mlast  = '0;
    for (int i = 0; i < 5; i++) mcnt[i] = 0;
  endtask

  task automatic modelStep();
    int idx;
    if (!rst_n) begin
      modelClear();
      exp_raw = 0;
      return;
    end
    idx = int'(rsel);
    exp_raw = (idx < 5) ? mcnt[idx] : 0;
    if (clr) begin
      modelClear();
    end else if (mstate == 0) begin
      if (en) mstate = 1;
    end else if (mstate == 1) begin
      mcnt[0]++;
      if (stall) begin
        mcnt[1]++;
      end else begin
        if (br_type) mcnt[2]++;
        if (flush) mcnt[3]++;
        if (i_addr != mlast) mcnt[4]++;
        mlast = i_addr;
      end
      if (finish) mstate = 2;
    end
  endtask

  task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk(tag, "running16", 32'(running16), 32'(mstate == 1));
    chk(tag, "done16",    32'(done16),    32'(mstate == 2));
    chk(tag, "ovf16",     32'(ovf16),     32'(anySat(16)));
    chk(tag, "rdata16",   32'(rdata16),   32'(sat(exp_raw, 16)));
    chk(tag, "running4",  32'(running4),  32'(mstate == 1));
    chk(tag, "done4",     32'(done4),     32'(mstate == 2));
    chk(tag, "ovf4",      32'(ovf4),      32'(anySat(4)));
    chk(tag, "rdata4",    32'(rdata4),    32'(sat(exp_raw, 4)));
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, then check 1ns later.
  task automatic applyStimulus(input logic e, input logic c, input logic f, input logic s,
                               input logic fl, input logic b, input logic [29:0] a,
                               input logic [2:0] rs, input string tag);
    en = e; clr = c; finish = f; stall = s; flush = fl; br_type = b; i_addr = a; rsel = rs;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycle(input logic [2:0] rs, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, rs, tag);
  endtask

  task automatic midReset(input string tag);
    #2;
    rst_n = 1'b0;
    modelClear();
    exp_raw = 0;
    #1;
    checkOutput(tag);
  endtask

  initial begin
    modelClear();
    exp_raw = 0;

    // Power-on reset, with inputs wiggling while held in reset.
    #1 midReset("por");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 30'($urandom), 3'($urandom), "in_reset");
    rst_n = 1'b1;
    idleCycle(3'd0, "post_reset");

    // Basic run: 10 unstalled cycles, fresh address every cycle, finish on the 10th.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 3'd0, "basic_en");
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, (i == 9), 1'b0, 1'b0, 1'b0, 30'(i + 1), 3'd0, "basic_run");
    chk("basic", "done_const", 32'(done16), 32'd1);
    idleCycle(3'd0, "basic_rd_cyc");
    chk("basic", "cyc_const", 32'(rdata16), 32'd10);
    idleCycle(3'd1, "basic_rd_stall");
    chk("basic", "stall_const", 32'(rdata16), 32'd0);
    idleCycle(3'd4, "basic_rd_fetch");
    chk("basic", "fetch_const", 32'(rdata16), 32'd10);

    // Readout map sweep while DONE, en/finish toggling must be ignored.
    for (int rs = 0; rs < 8; rs++) begin
      applyStimulus(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 30'($urandom), 3'(rs), "done_sweep");
      if (rs >= 5) chk("done_sweep", "unmapped_zero", 32'(rdata16), 32'd0);
    end
    chk("done_sweep", "still_done", 32'(done16), 32'd1);

    // Stalls dominate flush/branch; then two clean cycles.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 3'd0, "stall_clr");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 3'd0, "stall_en");
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'b0, (i == 5), (i < 4), 1'b1, 1'b1, 30'd7, 3'd0, "stall_run");
    idleCycle(3'd1, "stall_rd");
    chk("stall", "stall_const", 32'(rdata16), 32'd4);
    idleCycle(3'd3, "mis_rd");
    chk("stall", "mis_const", 32'(rdata16), 32'd2);
    idleCycle(3'd2, "br_rd");
    chk("stall", "br_const", 32'(rdata16), 32'd2);

    // Saturation: 20 run cycles overflow the 4-bit instance only.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 3'd0, "sat_clr");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 3'd0, "sat_en");
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'b0, (i == 19), 1'($urandom), 1'($urandom), 1'($urandom),
                    30'($urandom_range(0, 3)), 3'($urandom_range(0, 4)), "sat_run");
    idleCycle(3'd0, "sat_rd");
    chk("sat", "cyc4_const", 32'(rdata4), 32'd15);
    chk("sat", "cyc16_const", 32'(rdata16), 32'd20);
    chk("sat", "ovf4_const", 32'(ovf4), 32'd1);
    chk("sat", "ovf16_const", 32'(ovf16), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 3'd0, "sat_clr2");
    chk("sat", "ovf4_cleared", 32'(ovf4), 32'd0);
    chk("sat", "idle_after_clr", 32'(running4 | done4), 32'd0);
    idleCycle(3'd0, "sat_rd2");
    chk("sat", "cyc4_cleared", 32'(rdata4), 32'd0);

    // clr wins over finish in the same cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 3'd0, "clrfin_en");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'(i + 9), 3'd0, "clrfin_run");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 3'd0, "clrfin_both");
    chk("clrfin", "done_const", 32'(done16), 32'd0);
    chk("clrfin", "running_const", 32'(running16), 32'd0);
    idleCycle(3'd0, "clrfin_rd");
    chk("clrfin", "cyc_const", 32'(rdata16), 32'd0);

    // Asynchronous reset in the middle of a run, then a fresh run.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 3'd0, "arst_en");
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'(i + 1), 3'd0, "arst_run");
    midReset("arst_now");
    chk("arst", "rdata_const", 32'(rdata16), 32'd0);
    chk("arst", "running_const", 32'(running16), 32'd0);
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 30'($urandom), 3'd0, "arst_held");
    rst_n = 1'b1;
    idleCycle(3'd0, "arst_idle");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 3'd0, "arst_en2");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, (i == 2), 1'b0, 1'b0, 1'b0, 30'(i + 1), 3'd0, "arst_run2");
    idleCycle(3'd0, "arst_rd");
    chk("arst", "cyc_restart", 32'(rdata16), 32'd3);

    // Randomized traffic with occasional clr so runs restart.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0, 3'd0, "rand_clr");
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0),
                    1'($urandom), 1'($urandom), 30'($urandom_range(0, 3)),
                    3'($urandom), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
